// File: rtl/axi_nsaid_tagger.sv
// -----------------------------------------------------------------------------
// axi_nsaid_pkg / axi_nsaid_tagger
//
// Purpose:
//   Stamps the 4-bit non-secure agent ID (NSAID) on every AW and AR request
//   before it reaches the IOPMP checker. AW and AR each pass through a
//   one-entry register slice. Outstanding writes and reads are counted from
//   the slave-side handshake, so slice occupancy is included. A request that
//   carries a different NSAID from the one already in flight is held off
//   until all outstanding traffic has completed.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   nsaid_i         NSAID for new requests (quasi-static configuration)
//   slv_req_i       request from the upstream master
//   slv_resp_o      response to the upstream master
//   mst_req_o       NSAID-tagged request to the IOPMP
//   mst_resp_i      response from the IOPMP
//   nsaid_active_o  NSAID that owns the in-flight transactions
//   busy_o          any write or read outstanding
//   protocol_err_o  one-cycle pulse on a B/R-last with nothing outstanding
// -----------------------------------------------------------------------------
package axi_nsaid_pkg;

    typedef logic [3:0]  nsaid_t;
    typedef logic [3:0]  id_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ax_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        nsaid_t     nsaid;
    } ax_nsaid_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        ax_nsaid_chan_t aw;
        logic           aw_valid;
        w_chan_t        w;
        logic           w_valid;
        logic           b_ready;
        ax_nsaid_chan_t ar;
        logic           ar_valid;
        logic           r_ready;
    } req_nsaid_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

    // Copy an address-channel beat and attach the NSAID.
    function automatic ax_nsaid_chan_t stamp_nsaid(input ax_chan_t ax, input nsaid_t nsaid);
        ax_nsaid_chan_t res;
        res.id    = ax.id;
        res.addr  = ax.addr;
        res.len   = ax.len;
        res.size  = ax.size;
        res.burst = ax.burst;
        res.nsaid = nsaid;
        return res;
    endfunction

endpackage

module axi_nsaid_tagger
    import axi_nsaid_pkg::*;
#(
    parameter  int unsigned MaxTxns  = 8,
    localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  nsaid_t     nsaid_i,
    input  req_t       slv_req_i,
    output resp_t      slv_resp_o,
    output req_nsaid_t mst_req_o,
    input  resp_t      mst_resp_i,
    output logic [3:0] nsaid_active_o,
    output logic       busy_o,
    output logic       protocol_err_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);

    typedef logic [CntWidth-1:0] cnt_t;

    // Outstanding-counter update. Simultaneous +1/-1 leaves the count alone;
    // a -1 at zero saturates and is flagged by the caller.
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic inc, input logic dec);
        cnt_t res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CntWidth'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CntWidth'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    ax_nsaid_chan_t aw_q_r, ar_q_r;
    logic           aw_full_r, ar_full_r;
    cnt_t           wr_cnt_r, rd_cnt_r;
    nsaid_t         nsaid_active_r;
    logic           protocol_err_r;

    logic same_id_s, idle_s, admit_aw_s, admit_ar_s;
    logic slv_aw_ready_s, slv_ar_ready_s;
    logic aw_hs_s, ar_hs_s, aw_drain_s, ar_drain_s;
    logic wr_dec_s, rd_dec_s, uflow_s;

    // Admission: a new NSAID may only take over once nothing is outstanding.
    always_comb begin
        same_id_s      = (nsaid_i == nsaid_active_r);
        idle_s         = (wr_cnt_r == '0) && (rd_cnt_r == '0);
        admit_aw_s     = (wr_cnt_r < MaxCnt) && (same_id_s || idle_s);
        admit_ar_s     = (rd_cnt_r < MaxCnt) && (same_id_s || idle_s);
        // Ready may follow mst ready so the slice refills while it drains.
        slv_aw_ready_s = admit_aw_s && (!aw_full_r || mst_resp_i.aw_ready);
        slv_ar_ready_s = admit_ar_s && (!ar_full_r || mst_resp_i.ar_ready);
        aw_hs_s        = slv_req_i.aw_valid && slv_aw_ready_s;
        ar_hs_s        = slv_req_i.ar_valid && slv_ar_ready_s;
        aw_drain_s     = aw_full_r && mst_resp_i.aw_ready;
        ar_drain_s     = ar_full_r && mst_resp_i.ar_ready;
        wr_dec_s       = mst_resp_i.b_valid && slv_req_i.b_ready;
        rd_dec_s       = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
        uflow_s        = (wr_dec_s && (wr_cnt_r == '0)) || (rd_dec_s && (rd_cnt_r == '0));
    end

    // AW/AR slices, outstanding counters, active NSAID and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_q_r         <= '0;
            ar_q_r         <= '0;
            aw_full_r      <= 1'b0;
            ar_full_r      <= 1'b0;
            wr_cnt_r       <= '0;
            rd_cnt_r       <= '0;
            nsaid_active_r <= 4'h0;
            protocol_err_r <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_q_r    <= stamp_nsaid(slv_req_i.aw, nsaid_i);
                aw_full_r <= 1'b1;
            end else if (aw_drain_s) begin
                aw_full_r <= 1'b0;
            end
            if (ar_hs_s) begin
                ar_q_r    <= stamp_nsaid(slv_req_i.ar, nsaid_i);
                ar_full_r <= 1'b1;
            end else if (ar_drain_s) begin
                ar_full_r <= 1'b0;
            end
            if (aw_hs_s || ar_hs_s) begin
                nsaid_active_r <= nsaid_i;
            end
            wr_cnt_r       <= cnt_next(wr_cnt_r, aw_hs_s, wr_dec_s);
            rd_cnt_r       <= cnt_next(rd_cnt_r, ar_hs_s, rd_dec_s);
            protocol_err_r <= uflow_s;
        end
    end

    // Output assembly: AW/AR come from the slices, W/B/R pass straight through.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_q_r;
        mst_req_o.aw_valid = aw_full_r;
        mst_req_o.ar       = ar_q_r;
        mst_req_o.ar_valid = ar_full_r;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.r_ready  = slv_req_i.r_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = slv_aw_ready_s;
        slv_resp_o.ar_ready = slv_ar_ready_s;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b        = mst_resp_i.b;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.r        = mst_resp_i.r;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;

        nsaid_active_o = nsaid_active_r;
        busy_o         = (wr_cnt_r != '0) || (rd_cnt_r != '0);
        protocol_err_o = protocol_err_r;
    end

endmodule

// File: tb/tb_axi_nsaid_tagger.sv
// Directed testbench for axi_nsaid_tagger (MaxTxns = 4).
module tb_axi_nsaid_tagger;
    import axi_nsaid_pkg::*;

    logic       clk;
    logic       rst;
    nsaid_t     nsaid;
    req_t       slv_req;
    resp_t      slv_resp;
    req_nsaid_t mst_req;
    resp_t      mst_resp;
    logic [3:0] nsaid_active;
    logic       busy;
    logic       perr;

    int tests_run = 0;
    int tests_failed = 0;

    axi_nsaid_tagger #(.MaxTxns(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .nsaid_i       (nsaid),
        .slv_req_i     (slv_req),
        .slv_resp_o    (slv_resp),
        .mst_req_o     (mst_req),
        .mst_resp_i    (mst_resp),
        .nsaid_active_o(nsaid_active),
        .busy_o        (busy),
        .protocol_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; registered state is settled on return.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_aw(input logic v, input logic [3:0] id, input logic [31:0] addr);
        slv_req.aw_valid = v;
        slv_req.aw.id    = id;
        slv_req.aw.addr  = addr;
        slv_req.aw.len   = 8'd0;
        slv_req.aw.size  = 3'd2;
        slv_req.aw.burst = 2'd1;
    endtask

    task automatic set_ar(input logic v, input logic [3:0] id, input logic [31:0] addr);
        slv_req.ar_valid = v;
        slv_req.ar.id    = id;
        slv_req.ar.addr  = addr;
        slv_req.ar.len   = 8'd3;
        slv_req.ar.size  = 3'd2;
        slv_req.ar.burst = 2'd1;
    endtask

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready     = 1'b1;
        slv_req.r_ready     = 1'b1;
        mst_resp.aw_ready   = 1'b1;
        mst_resp.ar_ready   = 1'b1;
        mst_resp.w_ready    = 1'b1;
        mst_resp.r.last     = 1'b1;
        nsaid = 4'h0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
        check_eq("rst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_nsaid", 64'(nsaid_active), 64'd0);
        check_eq("rst_perr", 64'(perr), 64'd0);
        check_eq("rst_wr_cnt", 64'(dut.wr_cnt_r), 64'd0);

        // ---------------- single write ----------------
        nsaid = 4'h3;
        set_aw(1'b1, 4'h1, 32'h8000_0000);
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = 32'hDEAD_BEEF;
        slv_req.w.strb  = 4'hF;
        slv_req.w.last  = 1'b1;
        #1;
        check_eq("wr_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        check_eq("wr_w_valid", 64'(mst_req.w_valid), 64'd1);
        check_eq("wr_w_data", 64'(mst_req.w.data), 64'hDEAD_BEEF);
        check_eq("wr_w_ready", 64'(slv_resp.w_ready), 64'd1);
        check_eq("wr_aw_valid_pre", 64'(mst_req.aw_valid), 64'd0);
        tick();
        set_aw(1'b0, 4'h0, 32'h0);
        slv_req.w_valid = 1'b0;
        #1;
        check_eq("wr_aw_valid", 64'(mst_req.aw_valid), 64'd1);
        check_eq("wr_aw_nsaid", 64'(mst_req.aw.nsaid), 64'd3);
        check_eq("wr_aw_id", 64'(mst_req.aw.id), 64'd1);
        check_eq("wr_aw_addr", 64'(mst_req.aw.addr), 64'h8000_0000);
        check_eq("wr_aw_len", 64'(mst_req.aw.len), 64'd0);
        check_eq("wr_aw_size", 64'(mst_req.aw.size), 64'd2);
        check_eq("wr_aw_burst", 64'(mst_req.aw.burst), 64'd1);
        check_eq("wr_cnt_1", 64'(dut.wr_cnt_r), 64'd1);
        check_eq("wr_busy", 64'(busy), 64'd1);
        check_eq("wr_active", 64'(nsaid_active), 64'd3);
        tick();
        #1;
        check_eq("wr_aw_drained", 64'(mst_req.aw_valid), 64'd0);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'h1;
        mst_resp.b.resp  = 2'd0;
        #1;
        check_eq("wr_b_valid", 64'(slv_resp.b_valid), 64'd1);
        check_eq("wr_b_id", 64'(slv_resp.b.id), 64'd1);
        check_eq("wr_b_ready", 64'(mst_req.b_ready), 64'd1);
        check_eq("wr_busy_at_b", 64'(busy), 64'd1);
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check_eq("wr_cnt_0", 64'(dut.wr_cnt_r), 64'd0);
        check_eq("wr_busy_done", 64'(busy), 64'd0);
        check_eq("wr_no_perr", 64'(perr), 64'd0);

        // ---------------- back-to-back reads ----------------
        for (int i = 0; i < 4; i++) begin
            set_ar(1'b1, 4'(i), 32'h0000_1000 + 32'(i) * 32'h40);
            #1;
            check_eq("rd_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
            tick();
            #1;
            check_eq("rd_ar_valid", 64'(mst_req.ar_valid), 64'd1);
            check_eq("rd_ar_id", 64'(mst_req.ar.id), 64'(i));
            check_eq("rd_ar_addr", 64'(mst_req.ar.addr), 64'h1000 + 64'(i) * 64'h40);
        end
        set_ar(1'b0, 4'h0, 32'h0);
        check_eq("rd_cnt_4", 64'(dut.rd_cnt_r), 64'd4);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b0;
        tick();
        #1;
        check_eq("rd_nonlast", 64'(dut.rd_cnt_r), 64'd4);
        mst_resp.r.last = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            #1;
            check_eq("rd_cnt_dec", 64'(dut.rd_cnt_r), 64'(3 - j));
        end
        mst_resp.r_valid = 1'b0;
        check_eq("rd_perr", 64'(perr), 64'd0);

        // ---------------- outstanding limit ----------------
        for (int i = 0; i < 4; i++) begin
            set_ar(1'b1, 4'(i), 32'h2000 + 32'(i));
            tick();
        end
        set_ar(1'b1, 4'h9, 32'h0000_3000);
        #1;
        check_eq("lim_cnt", 64'(dut.rd_cnt_r), 64'd4);
        check_eq("lim_stall", 64'(slv_resp.ar_ready), 64'd0);
        tick();
        #1;
        check_eq("lim_stall2", 64'(slv_resp.ar_ready), 64'd0);
        mst_resp.r_valid = 1'b1;
        #1;
        check_eq("lim_stall_at_r", 64'(slv_resp.ar_ready), 64'd0);
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        check_eq("lim_cnt_3", 64'(dut.rd_cnt_r), 64'd3);
        check_eq("lim_ready", 64'(slv_resp.ar_ready), 64'd1);
        tick();
        set_ar(1'b0, 4'h0, 32'h0);
        #1;
        check_eq("lim_ar_id", 64'(mst_req.ar.id), 64'h9);
        check_eq("lim_cnt_4b", 64'(dut.rd_cnt_r), 64'd4);
        mst_resp.r_valid = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        mst_resp.r_valid = 1'b0;
        #1;
        check_eq("lim_cnt_0", 64'(dut.rd_cnt_r), 64'd0);

        // ---------------- NSAID switch while busy ----------------
        nsaid = 4'h3;
        set_aw(1'b1, 4'h1, 32'h4000);
        tick();
        set_aw(1'b0, 4'h0, 32'h0);
        tick();
        nsaid = 4'h5;
        set_aw(1'b1, 4'h2, 32'h5000);
        set_ar(1'b1, 4'h4, 32'h6000);
        #1;
        check_eq("sw_aw_stall", 64'(slv_resp.aw_ready), 64'd0);
        check_eq("sw_ar_stall", 64'(slv_resp.ar_ready), 64'd0);
        check_eq("sw_active_old", 64'(nsaid_active), 64'd3);
        tick();
        #1;
        check_eq("sw_aw_stall2", 64'(slv_resp.aw_ready), 64'd0);
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check_eq("sw_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        check_eq("sw_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
        tick();
        set_aw(1'b0, 4'h0, 32'h0);
        set_ar(1'b0, 4'h0, 32'h0);
        #1;
        check_eq("sw_aw_nsaid", 64'(mst_req.aw.nsaid), 64'd5);
        check_eq("sw_aw_addr", 64'(mst_req.aw.addr), 64'h5000);
        check_eq("sw_ar_nsaid", 64'(mst_req.ar.nsaid), 64'd5);
        check_eq("sw_active_new", 64'(nsaid_active), 64'd5);
        tick();
        mst_resp.b_valid = 1'b1;
        mst_resp.r_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        #1;
        check_eq("sw_idle", 64'(busy), 64'd0);

        // ---------------- backpressure ----------------
        mst_resp.aw_ready = 1'b0;
        set_aw(1'b1, 4'h6, 32'hA000_0000);
        tick();
        set_aw(1'b1, 4'h7, 32'hB000_0000);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_valid", 64'(mst_req.aw_valid), 64'd1);
            check_eq("bp_addr_held", 64'(mst_req.aw.addr), 64'hA000_0000);
            check_eq("bp_slv_stall", 64'(slv_resp.aw_ready), 64'd0);
            if (k < 4) tick();
        end
        mst_resp.aw_ready = 1'b1;
        #1;
        check_eq("bp_refill_ready", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        set_aw(1'b0, 4'h0, 32'h0);
        #1;
        check_eq("bp_second_valid", 64'(mst_req.aw_valid), 64'd1);
        check_eq("bp_second_id", 64'(mst_req.aw.id), 64'h7);
        check_eq("bp_second_addr", 64'(mst_req.aw.addr), 64'hB000_0000);
        tick();
        #1;
        check_eq("bp_drained", 64'(mst_req.aw_valid), 64'd0);
        check_eq("bp_cnt", 64'(dut.wr_cnt_r), 64'd2);
        mst_resp.b_valid = 1'b1;
        tick();
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check_eq("bp_cnt0", 64'(dut.wr_cnt_r), 64'd0);
        check_eq("bp_no_perr", 64'(perr), 64'd0);

        // ---------------- underflow ----------------
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check_eq("uf_perr", 64'(perr), 64'd1);
        check_eq("uf_cnt", 64'(dut.wr_cnt_r), 64'd0);
        tick();
        #1;
        check_eq("uf_perr_pulse", 64'(perr), 64'd0);

        // ---------------- reset with a full AW slice ----------------
        mst_resp.aw_ready = 1'b0;
        set_aw(1'b1, 4'h2, 32'hC000_0000);
        tick();
        set_aw(1'b0, 4'h0, 32'h0);
        #1;
        check_eq("rs_full", 64'(mst_req.aw_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rs_aw_valid", 64'(mst_req.aw_valid), 64'd0);
        check_eq("rs_wr_cnt", 64'(dut.wr_cnt_r), 64'd0);
        check_eq("rs_rd_cnt", 64'(dut.rd_cnt_r), 64'd0);
        check_eq("rs_busy", 64'(busy), 64'd0);
        check_eq("rs_active", 64'(nsaid_active), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_nsaid_tagger.md
Name: axi_nsaid_tagger

Overview:
- Sits directly upstream of the IOPMP checker.
- Converts a plain AXI master request (req_t) into an NSAID-tagged request (req_nsaid_t) by stamping the 4-bit non-secure agent ID on every AW and AR beat.
- Registers the AW and AR channels with a one-entry slice each, tracks outstanding reads and writes, and prevents requests carrying different NSAIDs from being in flight at the same time.

Parameters:
- MaxTxns, 8: max outstanding writes, and separately max outstanding reads; must be ≥1.
- CntWidth, $clog2(MaxTxns+1): outstanding-counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- nsaid_i  in  nsaid_t (4)  NSAID to stamp on new requests; quasi-static configuration.
- slv_req_i  in  req_t  request from the upstream master.
- slv_resp_o  out  resp_t  response to the upstream master.
- mst_req_o  out  req_nsaid_t  tagged request to the IOPMP.
- mst_resp_i  in  resp_t  response from the IOPMP.
- nsaid_active_o  out  4  NSAID currently owning the in-flight transactions.
- busy_o  out  1  high when wr_cnt != 0 or rd_cnt != 0.
- protocol_err_o  out  1  one-cycle pulse on a response with no matching outstanding request.

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - AW and AR slices empty: mst aw_valid = 0, ar_valid = 0.
  - wr_cnt = 0, rd_cnt = 0.
  - nsaid_active_o = 0, busy_o = 0, protocol_err_o = 0.
  - Reset mid-operation discards slice contents. Responses that arrive after reset for pre-reset requests count as underflow (see below).
- Admission (evaluated separately for AW and AR):
  - same_id = (nsaid_i == nsaid_active_o).
  - idle = (wr_cnt == 0 && rd_cnt == 0).
  - admit_aw = (wr_cnt < MaxTxns) && (same_id || idle).
  - admit_ar = (rd_cnt < MaxTxns) && (same_id || idle).
- AW slice:
  - slv aw_ready = admit_aw && (!aw_full || mst aw_ready).
  - On slave AW handshake: capture all aw fields, set aw.nsaid = nsaid_i, set nsaid_active_o <= nsaid_i, set aw_full.
  - Latency is exactly 1 cycle from slave handshake to mst aw_valid.
  - Full throughput: the slice accepts a new entry in the same cycle the master side drains it.
  - mst aw fields are held stable while aw_valid && !aw_ready.
- AR slice: identical to AW, using ar fields and admit_ar.
- Counting from the slave handshake means slice occupancy is already included in wr_cnt/rd_cnt.
- NSAID switch:
  - Only allowed when idle.
  - If nsaid_i differs while busy, new AW/AR stall (ready = 0) until both counters reach 0; in-flight traffic completes under the old NSAID.
  - Simultaneous AW and AR acceptance in an idle cycle with a new nsaid_i: both are stamped with nsaid_i.
- Counters:
  - wr_cnt: +1 on slave AW handshake; −1 on B handshake (mst b_valid && slv b_ready).
  - rd_cnt: +1 on slave AR handshake; −1 on R handshake with r.last = 1.
  - Increment and decrement in the same cycle: no change.
  - A decrement with count 0 holds the count at 0 and pulses protocol_err_o for one cycle.
  - Counters never exceed MaxTxns, because admission blocks at the limit.
- Pass-through (combinational, zero latency):
  - W: mst w/w_valid = slv w/w_valid; slv w_ready = mst w_ready. W may lead AW; no W gating.
  - B and R: slv_resp_o.b/b_valid/r/r_valid = mst_resp_i; mst b_ready/r_ready = slv b_ready/r_ready.
- No combinational path from mst aw_ready/ar_ready to mst aw_valid/ar_valid.

Test Plan:
- Single write:
  - Stimulus: nsaid_i = 4'h3; one AW (id 1, addr 0x8000_0000, len 0); W beat; B OKAY.
  - Required: mst aw_valid rises 1 cycle after the slave handshake with aw.nsaid = 3, all other fields unchanged.
  - Required: wr_cnt goes 0→1→0; busy_o drops the cycle after the B handshake.
- Back-to-back reads with downstream always ready:
  - Stimulus: 4 consecutive ARs.
  - Required: one mst ar_valid per cycle, no bubbles; rd_cnt reaches 4; returns to 0 only after 4 R beats with last = 1.
- Outstanding limit, MaxTxns = 2:
  - Stimulus: 3 ARs with R held off.
  - Required: 3rd AR sees ar_ready = 0 until the first R last handshake; accepted in the same cycle rd_cnt drops.
- NSAID switch while busy:
  - Stimulus: write outstanding under nsaid 3; nsaid_i changed to 5; new AW and AR presented.
  - Required: both stall; nsaid_active_o stays 3; after B completes, the AW is accepted with aw.nsaid = 5 and nsaid_active_o = 5.
- Backpressure:
  - Stimulus: mst aw_ready held 0 for 5 cycles with 2 AWs offered.
  - Required: first AW is held stable in the slice; second sees slv aw_ready = 0; both delivered in order once ready rises.
- Underflow and reset:
  - Stimulus: B response with wr_cnt = 0.
  - Required: protocol_err_o is high for exactly 1 cycle; wr_cnt stays 0.
  - Stimulus: rst_i asserted while an AW is full.
  - Required: aw_valid = 0 and counters = 0 on the next cycle.
